rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Shares the register file's single write port between two writeback sources: ALU result (port 0) and load unit (port 1). Arbitration is round-robin, and the block drives the registered `we3`/`wa3`/`wd3` write port of the 32x32 register file. A pending-write scoreboard lets the issue stage detect RAW hazards on the two read ports and WAW hazards on the destination register. The block sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `XLEN`, 32, data width
- `AW`, 5, register address width (32 registers)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `wb0_valid`  in  1  ALU writeback request
- `wb0_addr`  in  AW  ALU destination register
- `wb0_data`  in  XLEN  ALU result
- `wb0_ready`  out  1  ALU request accepted this cycle
- `wb1_valid`, `wb1_addr`, `wb1_data`, `wb1_ready`: same as port 0, for the load unit
- `we3`  out  1  register file write enable
- `wa3`  out  AW  register file write address
- `wd3`  out  XLEN  register file write data
- `iss_valid`  in  1  an instruction with destination `iss_rd` issues
- `iss_rd`  in  AW  destination of the issuing instruction
- `iss_ready`  out  1  no WAW conflict; issue may proceed
- `rs1`, `rs2`  in  AW  source registers of the issuing instruction
- `haz1`, `haz2`  out  1  the source register has a write pending

## Operation
- A transfer occurs on port k when `wbk_valid && wbk_ready` at a rising edge. The data must be held stable while valid and not ready.
- Ready is combinational from the other port's valid and the priority pointer. It never depends on the port's own valid:
  - `wb0_ready = !wb1_valid || prio==0`
  - `wb1_ready = !wb0_valid || prio==1`
- Priority pointer `prio`:
  - A 1-bit state.
  - It toggles to the other port only when both are valid and a grant is made.
  - A single-requester grant leaves it unchanged.
  - Fairness bound: a continuously valid requester waits at most 1 cycle.
- Accepted request to address 0: consumed normally (ready high), but `we3` stays 0 in the following cycle.
- Scoreboard: a 32-bit `pending` mask.
  - Set: `pending[iss_rd]` is set on `iss_valid && iss_ready` when `iss_rd != 0`.
  - Clear: `pending[wa3]` is cleared at the edge ending a cycle with `we3==1`.
  - Bit 0 is constant 0.
- `iss_ready = !pending[iss_rd]`. A pending bit being cleared in the same cycle still blocks; issue succeeds the next cycle.
- `haz1 = pending[rs1]`, `haz2 = pending[rs2]`. These are combinational, and `rs==0` always gives 0.
- Simultaneous set of reg A and clear of reg B in one cycle: both take effect. A==B cannot occur, because `iss_ready` blocks it.

## Timing
- Writeback latency is 1 cycle:
  - A transfer at the edge ending cycle N drives `we3`/`wa3`/`wd3` throughout cycle N+1.
  - The register file and scoreboard update at the edge ending N+1.
  - A read in N+2 returns the new value with `haz`=0.
- With no transfer in cycle N, `we3`=0 in N+1. `wa3`/`wd3` hold their last values.
- Throughput is one write per cycle. Back-to-back transfers produce `we3` high on consecutive cycles.
- Reset (`reset_n`=0 at a rising edge) sets:
  - `we3`=0, `wa3`=0, `wd3`=0
  - `pending`=0
  - `prio`=0
- Reset mid-operation: an accepted but unwritten request is dropped, and all pending bits clear.
- While `reset_n`=0: `wb0_ready`/`wb1_ready` follow the combinational equations, but transfers are discarded. `iss_ready` is 1 and `haz1`/`haz2` are 0 on the cycle after reset.

## Configuration
- `RF_SCOREBOARD_EN` defined: the pending mask and hazard logic are as described.
- `RF_SCOREBOARD_EN` undefined:
  - No `pending` state is built.
  - `iss_ready` is tied 1 and `haz1`/`haz2` are tied 0.
  - Issue inputs are ignored.
  - Arbitration and write-port timing are unchanged.

## Structure
- Shared package `rf_pkg` holds:
  - constants `XLEN`=32, `AW`=5, `NREG`=32
  - typedef `wb_req_t` (packed struct: `addr[AW-1:0]`, `data[XLEN-1:0]`)
- Sub-module `rr_arb2` holds the two-request round-robin arbiter: inputs `req[1:0]`, output `gnt[1:0]`, and the `prio` flop.
- The scoreboard and output registers live in the top module.

## Test plan
- Single port 0 write: `wb0_valid`, addr 5, data 0xDEADBEEF in cycle 0 -> `we3`=1, `wa3`=5, `wd3`=0xDEADBEEF in cycle 1; `we3`=0 in cycle 2.
- Both ports valid for 4 cycles, addrs 3/4 -> grants alternate 0,1,0,1; `wa3` sequence 3,4,3,4 on cycles 1-4.
- Write to x0 with data 0x1234 -> `wb0_ready`=1, `we3` stays 0; `haz1` for rs1=0 is always 0.
- Issue rd=7 in cycle 0 -> `haz1`=1 for rs1=7 and `iss_ready`=0 for rd=7 from cycle 1. Writeback addr 7 accepted in cycle 2 -> `we3` in cycle 3; `haz1`=0 and `iss_ready`=1 in cycle 4.
- Assert `reset_n`=0 for one edge right after a transfer on addr 9 with `pending[9]`=1 -> `we3`=0 next cycle, `haz` for rs=9 is 0, `prio`=0.
- Build without `RF_SCOREBOARD_EN`, issue rd=7 -> `haz1`=0 and `iss_ready`=1 in every cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
package rf_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Readiness of each side depends only on
// the other side's request and the priority pointer, never on its own request.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] rdy,
  output logic [1:0] gnt
);

  logic prio;

  assign rdy[0] = !req[1] || (prio == 1'b0);
  assign rdy[1] = !req[0] || (prio == 1'b1);
  assign gnt    = req & rdy;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio <= 1'b0;
    end else if (&req) begin
      // contention always yields a grant, so hand priority to the loser
      prio <= ~prio;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between ALU (port 0) and load unit
// (port 1). Define RF_SCOREBOARD_EN to build the pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW   = rf_pkg::AW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  output logic            wb1_ready,
  output logic            we3,
  output logic [AW-1:0]   wa3,
  output logic [XLEN-1:0] wd3,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            haz1,
  output logic            haz2
);

  import rf_pkg::*;

  logic [1:0] req;
  logic [1:0] rdy;
  logic [1:0] gnt;
  wb_req_t    sel;

  assign req = {wb1_valid, wb0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .rdy     (rdy),
    .gnt     (gnt)
  );

  assign wb0_ready = rdy[0];
  assign wb1_ready = rdy[1];

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sel.addr = wb0_addr;
    sel.data = wb0_data;
    if (gnt[1]) begin
      sel.addr = wb1_addr;
      sel.data = wb1_data;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= (|gnt) && (sel.addr != '0);
      if (|gnt) begin
        wa3 <= sel.addr;
        wd3 <= sel.data;
      end
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pending_nxt;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && iss_ready && (iss_rd != '0)) set_mask[iss_rd] = 1'b1;
    if (we3) clr_mask[wa3] = 1'b1;
    pending_nxt = (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= {pending_nxt[NREG-1:1], 1'b0};
    end
  end

  // A bit being cleared this cycle still blocks; issue retries next cycle.
  assign iss_ready = !pending[iss_rd];
  assign haz1      = pending[rs1];
  assign haz2      = pending[rs2];
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_rd, rs1, rs2};

  assign iss_ready = 1'b1;
  assign haz1      = 1'b0;
  assign haz2      = 1'b0;
`endif

endmodule
